jh512_target_check: RTL and testbench

//  Downstream consumer of the fully pipelined JH-512 hasher. Re-aligns each issued nonce with
//  its hash by a matching delay line, compares the hash metric against a share target, and

---
 rtl/jh512_target_check_if.sv | 30 +++
 rtl/jh512_target_check.sv | 120 ++++++++++++
 tb/tb_jh512_target_check.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jh512_target_check_if.sv
// rtl/jh512_target_check_if.sv - issue/hash/target inputs and found-nonce handshake bundle
// Purpose: groups the hasher-side inputs and the work-controller handshake of jh512_target_check.
// Ports:   master - drives issue_valid/issue_nonce/hash/target/found_ready,
//                   observes found_valid/found_nonce/overflow/drop_count/hash_count
//          slave  - the checker; the mirror image of master
interface jh512_target_check_if #(
   parameter int NONCE_W = 32,
   parameter int CNT_W   = 32
);
   logic               issue_valid;
   logic [NONCE_W-1:0] issue_nonce;
   logic [511:0]       hash;
   logic [63:0]        target;
   logic               found_valid;
   logic               found_ready;
   logic [NONCE_W-1:0] found_nonce;
   logic               overflow;
   logic [7:0]         drop_count;
   logic [CNT_W-1:0]   hash_count;

   modport master (
      output issue_valid, issue_nonce, hash, target, found_ready,
      input  found_valid, found_nonce, overflow, drop_count, hash_count
   );

   modport slave (
      input  issue_valid, issue_nonce, hash, target, found_ready,
      output found_valid, found_nonce, overflow, drop_count, hash_count
   );
endinterface

// File: rtl/jh512_target_check.sv
// rtl/jh512_target_check.sv - JH-512 share-target checker with nonce realignment and hit FIFO
// Purpose: delays each issued nonce by PIPE_LATENCY cycles so it lines up with its hash,
//          compares hash[511:448] against the share target, and queues winning nonces.
// Ports:   clk   - clock, all logic on posedge
//          reset - synchronous active-high reset, wins over everything
//          flush - drops every nonce still inside the delay line (and this cycle's issue)
//          bus   - slave side of jh512_target_check_if: issue_valid/issue_nonce/hash/target in,
//                  found_valid/found_nonce/found_ready handshake, overflow, drop_count, hash_count
module jh512_target_check #(
   parameter int PIPE_LATENCY = 100,
   parameter int NONCE_W      = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 32
) (
   input logic                 clk,
   input logic                 reset,
   input logic                 flush,
   jh512_target_check_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   // nonce delay line matching the hasher pipeline
   logic [PIPE_LATENCY-1:0] dl_valid;
   logic [NONCE_W-1:0]      dl_nonce [PIPE_LATENCY];

   logic               av;
   logic [NONCE_W-1:0] an;
   logic [63:0]        metric;
   logic               unused_hash_bits;

   assign av               = dl_valid[PIPE_LATENCY-1];
   assign an               = dl_nonce[PIPE_LATENCY-1];
   assign metric           = bus.hash[511:448];
   assign unused_hash_bits = ^bus.hash[447:0];

   // Only the valid bits need clearing; stale nonces behind a cleared valid are harmless.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         dl_valid <= '0;
      end else begin
         dl_valid <= {dl_valid[PIPE_LATENCY-2:0], bus.issue_valid};
      end
   end

   always_ff @(posedge clk) begin
      dl_nonce[0] <= bus.issue_nonce;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
         dl_nonce[i] <= dl_nonce[i-1];
      end
   end

   // compare stage
   logic               c_hit;
   logic [NONCE_W-1:0] c_nonce;
   logic [CNT_W-1:0]   hash_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         c_hit    <= 1'b0;
         c_nonce  <= '0;
         hash_cnt <= '0;
      end else begin
         c_hit    <= av && (metric <= bus.target);
         c_nonce  <= an;
         hash_cnt <= hash_cnt + CNT_W'(av);
      end
   end

   // winning-nonce FIFO; pointers carry one extra wrap bit to tell full from empty
   logic [AW:0]        wr_ptr, rd_ptr;
   logic [NONCE_W-1:0] mem [FIFO_DEPTH];
   logic [NONCE_W-1:0] last_q;
   logic               empty, full, pop, push, drop;
   logic               ovf_q;
   logic [7:0]         drop_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && bus.found_ready;
   // a pop in the same cycle frees the slot the push needs
   assign push  = c_hit && (!full || pop);
   assign drop  = c_hit && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last_q <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr[AW-1:0]];
         end
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= c_nonce;
      end
   end

   assign bus.found_valid = !empty;
   // when empty, keep presenting the most recently consumed nonce
   assign bus.found_nonce = empty ? last_q : mem[rd_ptr[AW-1:0]];
   assign bus.overflow    = ovf_q;
   assign bus.drop_count  = drop_q;
   assign bus.hash_count  = hash_cnt;
endmodule

// File: tb/tb_jh512_target_check.sv
// tb/tb_jh512_target_check.sv - self-checking bench for jh512_target_check
module tb_jh512_target_check;
   localparam int L     = 100;
   localparam int NW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 32;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   jh512_target_check_if #(.NONCE_W(NW), .CNT_W(CW)) bus ();

   jh512_target_check #(
      .PIPE_LATENCY(L), .NONCE_W(NW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus)
   );

   typedef struct {
      logic [31:0] nonce;
      logic [63:0] metric;
      int          arrive;
   } rec_t;

   rec_t        inflight [$];
   logic [63:0] sched [int];
   logic [31:0] mq [$];
   logic [31:0] m_last;
   logic        m_c_hit;
   logic [31:0] m_c_nonce;
   logic        m_ovf;
   int          m_drop;
   logic [31:0] m_hcnt;
   logic [63:0] iss_metric;
   int          cyc;
   int          n_checks;
   int          n_fail;

   // Transaction-level reference: a nonce issued in cycle I reaches the compare in cycle I+L
   // unless a flush lands in cycles I..I+L-1; a hit joins the queue one edge later.
   task automatic step();
      rec_t        r;
      logic [511:0] h;
      if (reset) begin
         mq.delete();
         inflight.delete();
         m_last = '0; m_c_hit = 1'b0; m_c_nonce = '0;
         m_ovf = 1'b0; m_drop = 0; m_hcnt = '0;
      end else begin
         if (mq.size() > 0 && bus.found_ready) m_last = mq.pop_front();
         if (m_c_hit) begin
            if (mq.size() == DEPTH) begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end else begin
               mq.push_back(m_c_nonce);
            end
         end
         m_c_hit = 1'b0;
         if (inflight.size() > 0 && inflight[0].arrive == cyc) begin
            r = inflight.pop_front();
            m_hcnt++;
            m_c_hit   = (r.metric <= bus.target);
            m_c_nonce = r.nonce;
         end
         if (flush) begin
            inflight.delete();
         end else if (bus.issue_valid) begin
            r.nonce  = bus.issue_nonce;
            r.metric = iss_metric;
            r.arrive = cyc + L;
            inflight.push_back(r);
         end
      end
      if (bus.issue_valid) sched[cyc + L] = iss_metric;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 16; i++) h[i*32 +: 32] = $urandom;
      if (sched.exists(cyc)) h[511:448] = sched[cyc];
      bus.hash = h;
   endtask

   task automatic issue(input logic [31:0] n, input logic [63:0] m);
      bus.issue_valid = 1'b1;
      bus.issue_nonce = n;
      iss_metric      = m;
      step();
      bus.issue_valid = 1'b0;
   endtask

   task automatic run_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks += 5;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL reset_found_valid: got %b want 0", bus.found_valid); end
      if (bus.found_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_found_nonce: got %h want 0", bus.found_nonce); end
      if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
      if (bus.drop_count !== 8'h0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", bus.drop_count); end
      if (bus.hash_count !== 32'h0) begin n_fail++; $display("FAIL reset_hash_count: got %0d want 0", bus.hash_count); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_hit();
      int c0 = cyc;
      int early = 0;
      bus.target = 64'h20;
      issue(32'h1234, 64'h10);
      while (cyc < c0 + L + 2) begin
         if (bus.found_valid) early++;
         step();
      end
      n_checks += 4;
      if (early !== 0) begin n_fail++; $display("FAIL single_early: found_valid high %0d cycles too soon, want 0", early); end
      if (bus.found_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: found_valid %b at issue+%0d, want 1", bus.found_valid, L + 2); end
      if (bus.found_nonce !== 32'h1234) begin n_fail++; $display("FAIL single_nonce: got %h want 1234", bus.found_nonce); end
      if (bus.hash_count !== 32'd1) begin n_fail++; $display("FAIL single_hash_count: got %0d want 1", bus.hash_count); end
      bus.found_ready = 1'b1;
      step();
      bus.found_ready = 1'b0;
      n_checks += 2;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_empty: found_valid %b want 0", bus.found_valid); end
      if (bus.found_nonce !== 32'h1234) begin n_fail++; $display("FAIL single_hold_last: got %h want 1234", bus.found_nonce); end
   endtask

   task automatic test_threshold();
      int c0 = cyc;
      bus.target = 64'h20;
      issue(32'h2001, 64'h21);
      issue(32'h2002, 64'h20);
      run_until(c0 + L + 2);
      n_checks += 2;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL thr_above_target: found_valid %b want 0", bus.found_valid); end
      if (bus.hash_count !== 32'd3) begin n_fail++; $display("FAIL thr_hash_count: got %0d want 3", bus.hash_count); end
      step();
      n_checks += 2;
      if (bus.found_valid !== 1'b1) begin n_fail++; $display("FAIL thr_equal_hit: found_valid %b want 1", bus.found_valid); end
      if (bus.found_nonce !== 32'h2002) begin n_fail++; $display("FAIL thr_equal_nonce: got %h want 2002", bus.found_nonce); end
      bus.found_ready = 1'b1;
      step();
      bus.found_ready = 1'b0;
   endtask

   task automatic test_target_zero();
      int c0 = cyc;
      bus.target = 64'h0;
      issue(32'h3001, 64'h0);
      issue(32'h3002, 64'h1);
      run_until(c0 + L + 2);
      n_checks += 2;
      if (bus.found_valid !== 1'b1) begin n_fail++; $display("FAIL zero_hit: found_valid %b want 1", bus.found_valid); end
      if (bus.found_nonce !== 32'h3001) begin n_fail++; $display("FAIL zero_nonce: got %h want 3001", bus.found_nonce); end
      bus.found_ready = 1'b1;
      step();
      bus.found_ready = 1'b0;
      step();
      n_checks++;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL zero_miss_metric1: found_valid %b want 0", bus.found_valid); end
   endtask

   task automatic test_overflow();
      int c0 = cyc;
      bus.target = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.found_ready = 1'b0;
      for (int k = 1; k <= 6; k++) issue(32'(k), {$urandom, $urandom});
      run_until(c0 + L + 8);
      n_checks += 3;
      if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'd1) begin
         n_fail++; $display("FAIL ovf_head: valid %b nonce %h, want 1 and 1", bus.found_valid, bus.found_nonce);
      end
      if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
      if (bus.drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_count: got %0d want 2", bus.drop_count); end
      bus.found_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'(k)) begin
            n_fail++; $display("FAIL ovf_pop_order: valid %b nonce %h, want 1 and %h", bus.found_valid, bus.found_nonce, k);
         end
         step();
      end
      bus.found_ready = 1'b0;
      n_checks++;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: found_valid %b want 0", bus.found_valid); end
   endtask

   task automatic test_full_push_pop();
      int c0 = cyc;
      bus.target = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.found_ready = 1'b0;
      for (int k = 0; k < 5; k++) issue(32'h50 + 32'(k), {$urandom, $urandom});
      // four entries stored, fifth hit in the compare stage: pop and push on the same edge
      run_until(c0 + L + 5);
      bus.found_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h50 + 32'(k)) begin
            n_fail++; $display("FAIL fpp_order: valid %b nonce %h, want 1 and %h", bus.found_valid, bus.found_nonce, 32'h50 + k);
         end
         step();
      end
      bus.found_ready = 1'b0;
      n_checks += 2;
      if (bus.drop_count !== 8'd2) begin n_fail++; $display("FAIL fpp_no_drop: drop_count %0d want 2", bus.drop_count); end
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained: found_valid %b want 0", bus.found_valid); end
   endtask

   task automatic flush_case(input int flush_off, input logic early_pop, input string tag);
      int          c0 = cyc;
      int          fc = c0 + flush_off;
      logic [31:0] exp_q [$];
      logic [31:0] got_q [$];
      bus.target      = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.found_ready = early_pop;
      for (int k = 0; k < 10; k++) begin
         flush = (cyc == fc);
         issue(32'h100 + 32'(k), {$urandom, $urandom});
         flush = 1'b0;
         if (!(fc >= c0 + k && fc <= c0 + k + L - 1)) exp_q.push_back(32'h100 + 32'(k));
      end
      while (cyc < c0 + L + 15) begin
         flush = (cyc == fc);
         if (bus.found_valid && bus.found_ready) got_q.push_back(bus.found_nonce);
         step();
         flush = 1'b0;
      end
      bus.found_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (bus.found_valid && bus.found_ready) got_q.push_back(bus.found_nonce);
         step();
      end
      bus.found_ready = 1'b0;
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL flush_%s_count: got %0d hits want %0d", tag, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL flush_%s_nonce: got %h want %h", tag, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_flush();
      flush_case(5, 1'b1, "early");
      flush_case(L + 3, 1'b0, "late");
   endtask

   task automatic test_random();
      logic [63:0] tgt;
      logic [31:0] exp_fn;
      logic        exp_fv;
      int          bad = 0;
      tgt = {$urandom, $urandom};
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       tgt = 64'h0;
               1:       tgt = 64'hFFFF_FFFF_FFFF_FFFF;
               default: tgt = {$urandom, $urandom};
            endcase
         end
         bus.target      = tgt;
         bus.found_ready = ($urandom_range(0, 1) == 1);
         flush           = ($urandom_range(0, 99) == 0);
         bus.issue_valid = ($urandom_range(0, 9) < 6);
         bus.issue_nonce = $urandom;
         iss_metric      = ($urandom_range(0, 1) == 1) ? tgt + 64'(1) - 64'($urandom_range(0, 2)) : {$urandom, $urandom};
         step();
         exp_fv = (mq.size() != 0);
         exp_fn = exp_fv ? mq[0] : m_last;
         n_checks++;
         if (bus.found_valid !== exp_fv || bus.found_nonce !== exp_fn || bus.overflow !== m_ovf ||
             bus.drop_count !== 8'(m_drop) || bus.hash_count !== m_hcnt) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL random_cycle%0d: got v%b n%h o%b d%0d h%0d want v%b n%h o%b d%0d h%0d", cyc,
                        bus.found_valid, bus.found_nonce, bus.overflow, bus.drop_count, bus.hash_count,
                        exp_fv, exp_fn, m_ovf, m_drop, m_hcnt);
         end
      end
      flush = 1'b0;
      bus.issue_valid = 1'b0;
      bus.found_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int c0;
      int seen = 0;
      bus.target = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.found_ready = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 3; k++) issue(32'h700 + 32'(k), {$urandom, $urandom});
      run_until(c0 + L + 6);
      for (int k = 0; k < 3; k++) issue(32'h800 + 32'(k), {$urandom, $urandom});
      for (int n = 0; n < 10; n++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks += 5;
      if (bus.found_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_found_valid: got %b want 0", bus.found_valid); end
      if (bus.found_nonce !== 32'h0) begin n_fail++; $display("FAIL rst_mid_found_nonce: got %h want 0", bus.found_nonce); end
      if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow: got %b want 0", bus.overflow); end
      if (bus.drop_count !== 8'h0) begin n_fail++; $display("FAIL rst_mid_drop_count: got %0d want 0", bus.drop_count); end
      if (bus.hash_count !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hash_count: got %0d want 0", bus.hash_count); end
      c0 = cyc;
      while (cyc < c0 + L + 5) begin
         if (bus.found_valid) seen++;
         step();
      end
      n_checks += 2;
      if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_stale: found_valid high %0d cycles, want 0", seen); end
      if (bus.hash_count !== 32'h0) begin n_fail++; $display("FAIL rst_mid_stale_count: got %0d want 0", bus.hash_count); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_nonce = '0;
      bus.target      = '0;
      bus.found_ready = 1'b0;
      bus.hash        = '0;
      iss_metric = '0;
      m_last = '0; m_c_hit = 1'b0; m_c_nonce = '0; m_ovf = 1'b0; m_drop = 0; m_hcnt = '0;
      test_reset();
      test_single_hit();
      test_threshold();
      test_target_zero();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
